// File: rtl/mul_ctrl_pkg.sv
// Shared types and width helpers for the multiplier arbiter and its
// round-robin selector.
package mul_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RETURN = 2'd3
    } state_t;

    localparam int DEF_DATA_SIZE    = 16;
    localparam int DEF_ID_SIZE      = 8;
    localparam int DEF_NUM_REQ      = 2;
    localparam int DEF_ISSUE_CYCLES = 2;
    localparam int DEF_TIMEOUT      = 64;

    // Tagged result word: {id, flag, product}
    function automatic int res_width(input int data_size, input int id_size);
        return data_size + 1 + id_size;
    endfunction

    // Counter wide enough to hold the value max_count itself
    function automatic int cnt_width(input int max_count);
        return (max_count < 2) ? 1 : $clog2(max_count + 1);
    endfunction

    // Index width for a requester pointer
    function automatic int ptr_width(input int num_req);
        return (num_req < 2) ? 1 : $clog2(num_req);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: scans upward from ptr (wrapping)
// and picks the first active request.
module rr_arbiter
    import mul_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   idx
);

    // First active request at or after ptr wins
    always_comb begin : scan
        int  cand;
        logic found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = PTR_W'(cand);
            end
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one multiplier between NUM_REQ requesters: grants one operand
// pair at a time, holds it on the multiplier for ISSUE_CYCLES, waits for
// the result and steers it back to the requester that issued it.
module mul_arbiter
    import mul_ctrl_pkg::*;
#(
    parameter int DATA_SIZE     = DEF_DATA_SIZE,
    parameter int MUL_DATA_SIZE = DATA_SIZE / 2,
    parameter int ID_SIZE       = DEF_ID_SIZE,
    parameter int NUM_REQ       = DEF_NUM_REQ,
    parameter int ISSUE_CYCLES  = DEF_ISSUE_CYCLES,
    parameter int TIMEOUT       = DEF_TIMEOUT,
    localparam int RES_W        = res_width(DATA_SIZE, ID_SIZE)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*MUL_DATA_SIZE-1:0] req_a,
    input  logic [NUM_REQ*MUL_DATA_SIZE-1:0] req_b,
    input  logic [NUM_REQ*ID_SIZE-1:0]       req_id,
    output logic [NUM_REQ-1:0]               req_pop,
    output logic                             mul_valid,
    output logic [MUL_DATA_SIZE-1:0]         mul_a,
    output logic [MUL_DATA_SIZE-1:0]         mul_b,
    output logic [ID_SIZE-1:0]               mul_id,
    input  logic                             mul_ready,
    input  logic                             mul_res_valid,
    input  logic [RES_W-1:0]                 mul_result,
    output logic                             mul_written,
    output logic [NUM_REQ-1:0]               res_valid,
    output logic [RES_W-1:0]                 res_data,
    input  logic [NUM_REQ-1:0]               res_ready,
    output logic                             busy,
    output logic                             err
);

    localparam int PTR_W = ptr_width(NUM_REQ);
    localparam int ICW   = cnt_width(ISSUE_CYCLES);
    localparam int WCW   = cnt_width(TIMEOUT);

    state_t                   state_q, state_d;
    logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]         owner_q, owner_d;
    logic [ICW-1:0]           issue_cnt_q, issue_cnt_d;
    logic [WCW-1:0]           wait_cnt_q, wait_cnt_d;
    logic                     err_q, err_d;
    logic [MUL_DATA_SIZE-1:0] mul_a_q, mul_a_d;
    logic [MUL_DATA_SIZE-1:0] mul_b_q, mul_b_d;
    logic [ID_SIZE-1:0]       mul_id_q, mul_id_d;

    logic [NUM_REQ-1:0]       grant;
    logic [PTR_W-1:0]         grant_idx;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (grant),
        .idx   (grant_idx)
    );

    // State, pointers, counters and latched operands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            issue_cnt_q <= '0;
            wait_cnt_q  <= '0;
            err_q       <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            issue_cnt_q <= issue_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            mul_id_q    <= mul_id_d;
        end
    end

    // Next-state logic plus the grant and return handshakes
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        issue_cnt_d = issue_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        err_d       = err_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        mul_id_d    = mul_id_q;
        req_pop     = '0;
        mul_written = 1'b0;
        res_valid   = '0;

        case (state_q)
            ST_IDLE: begin
                // A grant is only made when the multiplier can take it
                if ((|req_valid) && mul_ready) begin
                    req_pop     = grant;
                    owner_d     = grant_idx;
                    issue_cnt_d = '0;
                    state_d     = ST_ISSUE;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (grant[i]) begin
                            mul_a_d  = req_a[i*MUL_DATA_SIZE +: MUL_DATA_SIZE];
                            mul_b_d  = req_b[i*MUL_DATA_SIZE +: MUL_DATA_SIZE];
                            mul_id_d = req_id[i*ID_SIZE +: ID_SIZE];
                        end
                    end
                end
            end
            ST_ISSUE: begin
                if (issue_cnt_q == ICW'(ISSUE_CYCLES - 1)) begin
                    issue_cnt_d = '0;
                    wait_cnt_d  = '0;
                    state_d     = ST_WAIT;
                end else begin
                    issue_cnt_d = issue_cnt_q + ICW'(1);
                end
            end
            ST_WAIT: begin
                // Counter saturates at TIMEOUT; err stays set until reset
                if (mul_res_valid) begin
                    wait_cnt_d = '0;
                    state_d    = ST_RETURN;
                end else if (wait_cnt_q != WCW'(TIMEOUT)) begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                    if (wait_cnt_q == WCW'(TIMEOUT - 1)) begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RETURN: begin
                res_valid[owner_q] = 1'b1;
                mul_written        = res_ready[owner_q];
                if (res_ready[owner_q]) begin
                    rr_ptr_d = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mul_valid = (state_q == ST_ISSUE);
    assign busy      = (state_q != ST_IDLE);
    assign err       = err_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign mul_id    = mul_id_q;
    assign res_data  = mul_result;

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: behavioural requester FIFOs and multiplier,
// expected results queued at each grant and checked when returned.
module tb_mul_arbiter;

    localparam int DS  = 16;
    localparam int MDS = 8;
    localparam int IDS = 8;
    localparam int NR  = 2;
    localparam int IC  = 2;
    localparam int TO  = 64;
    localparam int RW  = DS + 1 + IDS;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NR-1:0]    req_valid;
    logic [NR*MDS-1:0] req_a, req_b;
    logic [NR*IDS-1:0] req_id;
    logic [NR-1:0]    req_pop;
    logic             mul_valid;
    logic [MDS-1:0]   mul_a, mul_b;
    logic [IDS-1:0]   mul_id;
    logic             mul_ready;
    logic             mul_res_valid;
    logic [RW-1:0]    mul_result;
    logic             mul_written;
    logic [NR-1:0]    res_valid;
    logic [RW-1:0]    res_data;
    logic [NR-1:0]    res_ready;
    logic             busy;
    logic             err;

    mul_arbiter #(
        .DATA_SIZE     (DS),
        .MUL_DATA_SIZE (MDS),
        .ID_SIZE       (IDS),
        .NUM_REQ       (NR),
        .ISSUE_CYCLES  (IC),
        .TIMEOUT       (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_id        (req_id),
        .req_pop       (req_pop),
        .mul_valid     (mul_valid),
        .mul_a         (mul_a),
        .mul_b         (mul_b),
        .mul_id        (mul_id),
        .mul_ready     (mul_ready),
        .mul_res_valid (mul_res_valid),
        .mul_result    (mul_result),
        .mul_written   (mul_written),
        .res_valid     (res_valid),
        .res_data      (res_data),
        .res_ready     (res_ready),
        .busy          (busy),
        .err           (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            owner;
        logic [RW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   grant_log[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    // requester sources and multiplier model state
    int          rq_cnt [NR];
    logic [7:0]  rq_a [NR];
    logic [7:0]  rq_b [NR];
    logic [7:0]  rq_id [NR];
    bit          mr_en;
    bit          mdl_busy;
    bit          mdl_never;
    int          mdl_lat;
    int          mdl_cnt;
    logic [7:0]  cap_a, cap_b, cap_id;

    // values sampled at the falling edge of the current cycle
    logic [NR-1:0] s_pop, s_rv;
    logic          s_mv, s_mw, s_busy, s_err, s_mrv, s_mready;
    logic [RW-1:0] s_rd;
    logic [7:0]    s_ma, s_mb, s_mid;

    task automatic drive_inputs();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]          = (rq_cnt[i] > 0);
            req_a[i*MDS +: MDS]   = rq_a[i];
            req_b[i*MDS +: MDS]   = rq_b[i];
            req_id[i*IDS +: IDS]  = rq_id[i];
        end
        mul_ready = mr_en && !mdl_busy;
    endtask

    task automatic clear_bench();
        sb.delete();
        grant_log.delete();
        for (int i = 0; i < NR; i++) begin
            rq_cnt[i] = 0;
            rq_a[i]   = 8'($urandom);
            rq_b[i]   = 8'($urandom);
            rq_id[i]  = 8'($urandom);
        end
        mr_en         = 1'b1;
        mdl_busy      = 1'b0;
        mdl_never     = 1'b0;
        mdl_lat       = 4;
        mdl_cnt       = 0;
        mul_res_valid = 1'b0;
        mul_result    = '0;
        res_ready     = 2'b11;
        drive_inputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_bench();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // One clock: sample, score returned results, then advance the models
    task automatic cycle();
        logic [NR-1:0] exp_rv;
        exp_t          e;
        @(negedge clk);
        s_pop = req_pop;  s_rv = res_valid; s_mv = mul_valid; s_mw = mul_written;
        s_busy = busy;    s_err = err;      s_mrv = mul_res_valid; s_mready = mul_ready;
        s_rd = res_data;  s_ma = mul_a;     s_mb = mul_b;     s_mid = mul_id;
        cyc++;
        if (s_rv != '0) begin
            if (sb.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL sb_unexpected: res_valid=%b with no result pending", s_rv);
            end else begin
                exp_rv = 2'b01 << sb[0].owner;
                n_vec++;
                if (s_rv !== exp_rv || s_rd !== sb[0].data) begin
                    n_err++;
                    $display("FAIL sb_result: got res_valid=%b data=%h, want res_valid=%b data=%h",
                             s_rv, s_rd, exp_rv, sb[0].data);
                end
                n_vec++;
                if (s_mw !== res_ready[sb[0].owner]) begin
                    n_err++;
                    $display("FAIL sb_written: got mul_written=%b, want %b", s_mw, res_ready[sb[0].owner]);
                end
                if (res_ready[sb[0].owner] === 1'b1) void'(sb.pop_front());
            end
        end else if (s_mw !== 1'b0) begin
            n_vec++; n_err++;
            $display("FAIL written_spurious: got mul_written=%b, want 0 outside return", s_mw);
        end
        if (s_pop != '0) begin
            n_vec++;
            if (!s_mready || $countones(s_pop) != 1) begin
                n_err++;
                $display("FAIL pop_illegal: got req_pop=%b with mul_ready=%b, want one-hot only when ready",
                         s_pop, s_mready);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (s_pop[i]) begin
                e.owner = i;
                e.data  = {rq_id[i], 1'b0, 16'(rq_a[i]) * 16'(rq_b[i])};
                sb.push_back(e);
                grant_log.push_back(i);
                rq_cnt[i]--;
                rq_a[i]  = 8'($urandom);
                rq_b[i]  = 8'($urandom);
                rq_id[i] = 8'($urandom);
            end
        end
        if (s_mw) begin
            mdl_busy      = 1'b0;
            mul_res_valid = 1'b0;
        end else if (!mdl_busy && s_mv) begin
            mdl_busy = 1'b1;
            cap_a = s_ma; cap_b = s_mb; cap_id = s_mid;
            mdl_cnt = mdl_lat;
        end else if (mdl_busy && !mul_res_valid && !mdl_never) begin
            if (mdl_cnt <= 1) begin
                mul_res_valid = 1'b1;
                mul_result    = {cap_id, 1'b0, 16'(cap_a) * 16'(cap_b)};
            end else begin
                mdl_cnt--;
            end
        end
        drive_inputs();
    endtask

    task automatic drain(input int bound);
        bit done;
        done = 1'b0;
        for (int k = 0; k < bound && !done; k++) begin
            cycle();
            if (sb.size() == 0 && rq_cnt[0] == 0 && rq_cnt[1] == 0 && !s_busy) done = 1'b1;
        end
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL drain_timeout: got %0d results pending after %0d cycles, want 0", sb.size(), bound);
        end
    endtask

    task automatic test_reset();
        do_reset();
        cycle();
        n_vec++;
        if ({s_pop, s_mv, s_mw, s_rv, s_busy, s_err} !== '0) begin
            n_err++;
            $display("FAIL reset_ctrl: got pop=%b mv=%b mw=%b rv=%b busy=%b err=%b, want all 0",
                     s_pop, s_mv, s_mw, s_rv, s_busy, s_err);
        end
        n_vec++;
        if ({s_ma, s_mb, s_mid} !== 24'h0) begin
            n_err++;
            $display("FAIL reset_data: got a=%h b=%h id=%h, want 0", s_ma, s_mb, s_mid);
        end
    endtask

    task automatic test_single();
        int t_pop, t_mv, t_mrv, t_rv, t_mw, pop_n, mv_n;
        logic [RW-1:0] rd, exp_rd;
        exp_rd = {8'h5A, 1'b0, 16'd143};
        t_pop = -1; t_mv = -1; t_mrv = -1; t_rv = -1; t_mw = -1; pop_n = 0; mv_n = 0; rd = '0;
        do_reset();
        mdl_lat = 20;
        rq_a[0] = 8'd13; rq_b[0] = 8'd11; rq_id[0] = 8'h5A; rq_cnt[0] = 1;
        drive_inputs();
        for (int k = 0; k < 100 && t_mw < 0; k++) begin
            cycle();
            if (s_pop == 2'b01) begin pop_n++; if (t_pop < 0) t_pop = cyc; end
            if (s_mv) begin mv_n++; if (t_mv < 0) t_mv = cyc; end
            if (s_mrv && t_mrv < 0) t_mrv = cyc;
            if (s_rv == 2'b01 && t_rv < 0) begin t_rv = cyc; rd = s_rd; end
            if (s_mw && t_mw < 0) t_mw = cyc;
        end
        n_vec++;
        if (pop_n !== 1) begin n_err++; $display("FAIL single_pop: got %0d pop cycles, want 1", pop_n); end
        n_vec++;
        if (mv_n !== IC || t_mv !== t_pop + 1) begin
            n_err++;
            $display("FAIL single_issue: got %0d valid cycles from cycle %0d, want %0d from %0d",
                     mv_n, t_mv, IC, t_pop + 1);
        end
        n_vec++;
        if (rd !== exp_rd) begin n_err++; $display("FAIL single_data: got %h, want %h", rd, exp_rd); end
        n_vec++;
        if (t_mrv < 0 || t_rv !== t_mrv + 1 || t_mw !== t_rv) begin
            n_err++;
            $display("FAIL single_return: got rv at %0d mw at %0d, want both at %0d", t_rv, t_mw, t_mrv + 1);
        end
        drain(20);
    endtask

    task automatic test_fairness();
        do_reset();
        mdl_lat = 3;
        rq_cnt[0] = 3; rq_cnt[1] = 3;
        drive_inputs();
        drain(400);
        n_vec++;
        if (grant_log.size() !== 6) begin
            n_err++;
            $display("FAIL fair_count: got %0d grants, want 6", grant_log.size());
        end
        for (int k = 0; k < grant_log.size(); k++) begin
            n_vec++;
            if (grant_log[k] !== k % 2) begin
                n_err++;
                $display("FAIL fair_order[%0d]: got requester %0d, want %0d", k, grant_log[k], k % 2);
            end
        end
    endtask

    task automatic test_backpressure();
        bit seen;
        seen = 1'b0;
        do_reset();
        mdl_lat = 5;
        res_ready = 2'b01;
        rq_cnt[1] = 1;
        drive_inputs();
        for (int k = 0; k < 100 && !seen; k++) begin
            cycle();
            if (s_rv[1]) seen = 1'b1;
        end
        n_vec++;
        if (!seen) begin n_err++; $display("FAIL bp_wait: got no res_valid[1] in 100 cycles, want one"); end
        for (int k = 0; k < 9; k++) begin
            cycle();
            n_vec++;
            if (s_rv !== 2'b10 || s_mw !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold: got rv=%b mw=%b, want rv=10 mw=0", s_rv, s_mw);
            end
        end
        res_ready = 2'b11;
        cycle();
        n_vec++;
        if (s_rv !== 2'b10 || s_mw !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release: got rv=%b mw=%b, want rv=10 mw=1", s_rv, s_mw);
        end
        cycle();
        n_vec++;
        if (s_rv !== 2'b00 || s_busy !== 1'b0) begin
            n_err++;
            $display("FAIL bp_idle: got rv=%b busy=%b, want 00 and 0", s_rv, s_busy);
        end
    endtask

    task automatic test_not_ready();
        do_reset();
        mr_en = 1'b0;
        rq_cnt[0] = 1; rq_cnt[1] = 1;
        drive_inputs();
        for (int k = 0; k < 5; k++) begin
            cycle();
            n_vec++;
            if (s_pop !== 2'b00 || s_busy !== 1'b0) begin
                n_err++;
                $display("FAIL nr_hold: got pop=%b busy=%b, want 00 and 0", s_pop, s_busy);
            end
        end
        mr_en = 1'b1;
        drive_inputs();
        cycle();
        n_vec++;
        if (s_pop !== 2'b01) begin n_err++; $display("FAIL nr_grant: got pop=%b, want 01", s_pop); end
        cycle();
        n_vec++;
        if (s_busy !== 1'b1 || s_mv !== 1'b1) begin
            n_err++;
            $display("FAIL nr_issue: got busy=%b mv=%b, want 1 and 1", s_busy, s_mv);
        end
        drain(200);
    endtask

    task automatic test_timeout();
        int k0;
        bit in_wait;
        k0 = 0; in_wait = 1'b0;
        do_reset();
        mdl_never = 1'b1;
        rq_cnt[0] = 1;
        drive_inputs();
        for (int k = 0; k < 20 && !in_wait; k++) begin
            cycle();
            if (s_mv) k0 = 1;
            else if (k0 == 1 && s_busy) in_wait = 1'b1;
        end
        n_vec++;
        if (!in_wait) begin n_err++; $display("FAIL to_enter: got no wait phase in 20 cycles, want one"); end
        for (int k = 1; k <= 70; k++) begin
            cycle();
            if (k == TO - 1) begin
                n_vec++;
                if (s_err !== 1'b0) begin n_err++; $display("FAIL to_early: got err=%b at %0d, want 0", s_err, k); end
            end
            if (k == TO || k == 70) begin
                n_vec++;
                if (s_err !== 1'b1 || s_busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL to_err: got err=%b busy=%b at %0d, want 1 and 1", s_err, s_busy, k);
                end
            end
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++;
        if ({req_pop, mul_valid, mul_written, res_valid, busy, err, mul_a, mul_b, mul_id} !== '0) begin
            n_err++;
            $display("FAIL to_reset: got pop=%b mv=%b mw=%b rv=%b busy=%b err=%b a=%h b=%h id=%h, want all 0",
                     req_pop, mul_valid, mul_written, res_valid, busy, err, mul_a, mul_b, mul_id);
        end
        clear_bench();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        mdl_lat = 3;
        rq_cnt[0] = 1;
        drive_inputs();
        drain(100);
        mdl_lat = 40;
        rq_a[1] = 8'hA5; rq_b[1] = 8'h3C; rq_id[1] = 8'h77; rq_cnt[1] = 1;
        drive_inputs();
        repeat (6) cycle();
        n_vec++;
        if (s_busy !== 1'b1 || s_mv !== 1'b0 || s_ma !== 8'hA5) begin
            n_err++;
            $display("FAIL mid_setup: got busy=%b mv=%b a=%h, want 1 0 a5", s_busy, s_mv, s_ma);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++;
        if ({busy, mul_valid, res_valid, mul_a, mul_b, mul_id} !== '0) begin
            n_err++;
            $display("FAIL mid_reset: got busy=%b mv=%b rv=%b a=%h b=%h id=%h, want all 0",
                     busy, mul_valid, res_valid, mul_a, mul_b, mul_id);
        end
        clear_bench();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        mdl_lat = 3;
        rq_cnt[0] = 1; rq_cnt[1] = 1;
        drive_inputs();
        drain(200);
        n_vec++;
        if (grant_log.size() < 1 || grant_log[0] !== 0) begin
            n_err++;
            $display("FAIL mid_regrant: got first grant %0d of %0d, want requester 0",
                     (grant_log.size() > 0) ? grant_log[0] : -1, grant_log.size());
        end
    endtask

    initial begin
        clear_bench();
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_not_ready();
        test_timeout();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
